// File: rtl/apb_master_pkg.sv
// Shared types and constants for the valid/ready to APB4 master bridge.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_t;

  localparam logic [2:0] APB_PPROT_DEFAULT = 3'b000;
  localparam int         APB_WAIT_CNT_W    = 16;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding request/response to APB4 master bridge with an ACCESS-phase
// timeout; every output is registered except req_ready.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [31:0]           pwdata,
  output logic [3:0]            pstrb,
  output logic [2:0]            pprot,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [31:0]           prdata
);

  localparam logic [APB_WAIT_CNT_W-1:0] TIMEOUT_CNT = APB_WAIT_CNT_W'(TIMEOUT);
  // APB addresses are word aligned; the two byte-offset bits are forced to zero.
  localparam logic [ADDR_WIDTH-1:0]     ADDR_MASK   = ~(ADDR_WIDTH'(3));

  apb_state_t                state_q;
  logic [APB_WAIT_CNT_W-1:0] wait_cnt_q;
  logic [APB_WAIT_CNT_W-1:0] wait_cnt_d;
  logic                      psel_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-1:0]     paddr_q;
  logic [31:0]               pwdata_q;
  logic [3:0]                pstrb_q;
  logic                      rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [31:0]               rsp_rdata_q;

  // Saturating increment so a huge TIMEOUT cannot wrap the counter.
  assign wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q   <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= req_write;
            paddr_q   <= req_addr & ADDR_MASK;
            pwdata_q  <= req_wdata;
            pstrb_q   <= req_write ? req_strb : 4'b0000;
          end
        end
        SETUP: begin
          state_q    <= ACCESS;
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
        end
        ACCESS: begin
          // A completing slave takes priority over a timeout in the same cycle.
          if (pready) begin
            state_q       <= RESP;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? 32'h0 : prdata;
            rsp_err_q     <= pslverr;
            rsp_timeout_q <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            if (wait_cnt_d >= TIMEOUT_CNT) begin
              state_q       <= RESP;
              psel_q        <= 1'b0;
              penable_q     <= 1'b0;
              rsp_valid_q   <= 1'b1;
              rsp_rdata_q   <= 32'h0;
              rsp_err_q     <= 1'b1;
              rsp_timeout_q <= 1'b1;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = APB_PPROT_DEFAULT;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: two-register APB slave model, response scoreboard,
// error, timeout, stall and mid-transfer reset scenarios.
module tb_apb_master_bridge;

  localparam int M_OK   = 0;
  localparam int M_ERR  = 1;
  localparam int M_HANG = 2;
  localparam int M_SLOW = 3;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;

  int          checks = 0;
  int          failures = 0;
  rsp_t        sb_q[$];
  logic [31:0] model_regs [2];

  int          slv_mode = M_OK;
  logic        force_pready = 1'b0;
  logic [31:0] slv_regs [2] = '{32'h0, 32'h0};
  int          slv_wait = 0;
  logic        addr_bad = 1'b0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  // Slave model: writes complete on the 2nd ACCESS cycle, reads on the 1st,
  // M_SLOW completes on the 4th, M_HANG never completes.
  always_comb begin
    pready = 1'b0;
    if (force_pready) pready = 1'b1;
    else if (psel && penable && slv_mode != M_HANG)
      pready = (slv_wait >= ((slv_mode == M_SLOW) ? 3 : (pwrite ? 1 : 0)));
  end
  assign pslverr = pready && (slv_mode == M_ERR);
  assign prdata  = (slv_mode == M_ERR) ? 32'hBAD0_5A5A : slv_regs[paddr[2]];

  always @(posedge pclk) begin
    slv_wait <= (psel && penable && !pready) ? slv_wait + 1 : 0;
    if (psel && penable && pready && pwrite && !pslverr)
      for (int b = 0; b < 4; b++)
        if (pstrb[b]) slv_regs[paddr[2]][8*b +: 8] <= pwdata[8*b +: 8];
  end

  always @(negedge pclk)
    if (psel && paddr[1:0] != 2'b00) addr_bad <= 1'b1;

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    return model_regs[addr[2]];
  endfunction

  task automatic do_xfer(input string name, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic exp_to, input int exp_acc, input int hold);
    rsp_t want;
    int   acc;
    int   n;
    sb_q.push_back({exp_rdata, exp_err, exp_to});
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL %s_req_ready got=%b exp=1", name, req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_strb = strb;
    @(negedge pclk);
    req_valid = 1'b0;
    checks++;
    if ({psel, penable, req_ready} !== 3'b100) begin
      failures++; $display("FAIL %s_setup got psel/penable/req_ready=%b exp=100", name, {psel, penable, req_ready});
    end
    acc = 0; n = 0;
    @(negedge pclk);
    while (!rsp_valid && n < 50) begin
      if (psel && penable) acc++;
      n++;
      @(negedge pclk);
    end
    checks++;
    if (!rsp_valid) begin
      failures++; $display("FAIL %s_rsp_wait got=no response exp=response within 50 cycles", name);
    end
    checks++;
    if (acc !== exp_acc) begin
      failures++; $display("FAIL %s_access_cycles got=%0d exp=%0d", name, acc, exp_acc);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++; $display("FAIL %s_scoreboard got=empty exp=entry", name);
      want = '0;
    end else begin
      want = sb_q.pop_front();
    end
    checks++;
    if (rsp_rdata !== want.rdata) begin
      failures++; $display("FAIL %s_rdata got=%h exp=%h", name, rsp_rdata, want.rdata);
    end
    checks++;
    if (rsp_err !== want.err) begin
      failures++; $display("FAIL %s_err got=%b exp=%b", name, rsp_err, want.err);
    end
    checks++;
    if (rsp_timeout !== want.to) begin
      failures++; $display("FAIL %s_timeout got=%b exp=%b", name, rsp_timeout, want.to);
    end
    for (int i = 0; i < hold; i++) begin
      force_pready = (i == 2);
      @(negedge pclk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== want.rdata || rsp_err !== want.err ||
          rsp_timeout !== want.to || req_ready !== 1'b0 || psel !== 1'b0) begin
        failures++;
        $display("FAIL %s_hold%0d got v=%b d=%h e=%b t=%b rr=%b psel=%b exp v=1 d=%h e=%b t=%b rr=0 psel=0",
                 name, i, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, req_ready, psel,
                 want.rdata, want.err, want.to);
      end
    end
    force_pready = 1'b0;
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      failures++; $display("FAIL %s_release got rsp_valid/req_ready=%b exp=01", name, {rsp_valid, req_ready});
    end
  endtask

  task automatic write_ok(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) model_regs[addr[2]][8*b +: 8] = data[8*b +: 8];
    do_xfer(name, 1'b1, addr, data, strb, 32'h0, 1'b0, 1'b0, 2, 0);
  endtask

  task automatic test_reset();
    @(negedge pclk);
    @(negedge pclk);
    checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, req_ready} !== 7'b0000001) begin
      failures++;
      $display("FAIL reset_ctrl got psel,pen,pwr,v,err,to,rr=%b exp=0000001",
               {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, req_ready});
    end
    checks++;
    if (paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || rsp_rdata !== 32'h0 || pprot !== 3'b000) begin
      failures++;
      $display("FAIL reset_data got paddr=%h pwdata=%h pstrb=%h rdata=%h pprot=%b exp all zero",
               paddr, pwdata, pstrb, rsp_rdata, pprot);
    end
    preset = 1'b0;
    @(negedge pclk);
  endtask

  task automatic test_write_read();
    slv_mode = M_OK;
    write_ok("wr0", 32'h0, 32'hDEADBEEF, 4'hF);
    do_xfer("rd0", 1'b0, 32'h0, 32'h0, 4'hF, model_read(32'h0), 1'b0, 1'b0, 1, 0);
  endtask

  task automatic test_second_reg();
    write_ok("wr4", 32'h4, 32'h12345678, 4'hF);
    do_xfer("rd4", 1'b0, 32'h4, 32'h0, 4'h0, model_read(32'h4), 1'b0, 1'b0, 1, 0);
    do_xfer("rd0b", 1'b0, 32'h0, 32'h0, 4'h0, model_read(32'h0), 1'b0, 1'b0, 1, 0);
    write_ok("wr4_part", 32'h7, 32'hAABBCCDD, 4'b0101);
    do_xfer("rd7", 1'b0, 32'h7, 32'h0, 4'h0, model_read(32'h4), 1'b0, 1'b0, 1, 0);
    checks++;
    if (addr_bad !== 1'b0) begin
      failures++; $display("FAIL paddr_align got=unaligned paddr seen exp=paddr[1:0]=0");
    end
  endtask

  task automatic test_slverr();
    slv_mode = M_ERR;
    do_xfer("err_wr", 1'b1, 32'h0, 32'h11111111, 4'hF, 32'h0, 1'b1, 1'b0, 2, 0);
    do_xfer("err_rd", 1'b0, 32'h4, 32'h0, 4'h0, 32'hBAD0_5A5A, 1'b1, 1'b0, 1, 0);
    slv_mode = M_OK;
    do_xfer("after_err", 1'b0, 32'h0, 32'h0, 4'h0, model_read(32'h0), 1'b0, 1'b0, 1, 0);
  endtask

  task automatic test_timeout();
    slv_mode = M_HANG;
    do_xfer("to_rd", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 4, 10);
    do_xfer("to_wr", 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, 1'b1, 4, 0);
    slv_mode = M_SLOW;
    do_xfer("edge_rd", 1'b0, 32'h4, 32'h0, 4'h0, model_read(32'h4), 1'b0, 1'b0, 4, 0);
    slv_mode = M_OK;
    force_pready = 1'b1;
    @(negedge pclk);
    force_pready = 1'b0;
    checks++;
    if ({psel, rsp_valid, req_ready} !== 3'b001) begin
      failures++; $display("FAIL idle_pready got psel/rsp_valid/req_ready=%b exp=001", {psel, rsp_valid, req_ready});
    end
  endtask

  task automatic test_stall();
    slv_mode = M_OK;
    do_xfer("stall_rd", 1'b0, 32'h4, 32'h0, 4'h0, model_read(32'h4), 1'b0, 1'b0, 1, 10);
  endtask

  task automatic test_reset_mid();
    int n;
    slv_mode = M_HANG;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0;
    @(negedge pclk);
    req_valid = 1'b0;
    n = 0;
    while (!(psel && penable) && n < 10) begin
      n++;
      @(negedge pclk);
    end
    checks++;
    if ({psel, penable} !== 2'b11) begin
      failures++; $display("FAIL rstmid_access got psel/penable=%b exp=11", {psel, penable});
    end
    preset = 1'b1;
    @(negedge pclk);
    checks++;
    if ({psel, penable, rsp_valid, req_ready} !== 4'b0001) begin
      failures++; $display("FAIL rstmid_state got psel,pen,v,rr=%b exp=0001", {psel, penable, rsp_valid, req_ready});
    end
    preset = 1'b0;
    slv_mode = M_OK;
    @(negedge pclk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_norsp got rsp_valid=%b exp=0", rsp_valid);
    end
    do_xfer("rstmid_rd", 1'b0, 32'h0, 32'h0, 4'h0, model_read(32'h0), 1'b0, 1'b0, 1, 0);
  endtask

  initial begin
    model_regs[0] = 32'h0;
    model_regs[1] = 32'h0;
    test_reset();
    test_write_read();
    test_second_reg();
    test_slverr();
    test_timeout();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
